// File: rtl/apb_slave_if.sv
// APB completer-side bus bundle.
//   master modport : drives PSEL/PENABLE/PWRITE/PADDR/PWDATA, receives PRDATA/PREADY/PSLVERR
//   slave  modport : mirror image of master
interface apb_slave_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
);
   logic                  PSEL;
   logic                  PENABLE;
   logic                  PWRITE;
   logic [ADDR_WIDTH-1:0] PADDR;
   logic [DATA_WIDTH-1:0] PWDATA;
   logic [DATA_WIDTH-1:0] PRDATA;
   logic                  PREADY;
   logic                  PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/apb_slave.sv
// Byte-wide APB completer with a register file, programmable wait states
// and an out-of-range error response.
//   PCLK    : clock, rising edge
//   PRESETn : asynchronous active-low reset
//   bus     : APB slave modport (PSEL, PENABLE, PWRITE, PADDR, PWDATA in;
//             PRDATA, PREADY, PSLVERR out, all outputs registered)
// DEPTH must be at least 2 and no larger than 2**ADDR_WIDTH.
module apb_slave #(
   parameter int DATA_WIDTH  = 8,
   parameter int ADDR_WIDTH  = 8,
   parameter int DEPTH       = 128,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        PCLK,
   input  logic        PRESETn,
   apb_slave_if.slave  bus
);
   localparam int IW = $clog2(DEPTH);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_READY = 2'd2;

   localparam logic [3:0]          WAIT_L  = WAIT_CYCLES[3:0];
   localparam logic [ADDR_WIDTH:0] DEPTH_W = DEPTH[ADDR_WIDTH:0];

   logic [1:0]            state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  write_q, write_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
   logic                  pready_q, pready_d;
   logic                  pslverr_q, pslverr_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic go_ready;   // entering READY on this edge
   logic mem_we;     // in-range write completes on this edge
   logic oor;        // address that will be latched is out of range

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      write_d   = write_q;
      wdata_d   = wdata_q;
      prdata_d  = prdata_q;
      pready_d  = 1'b0;
      pslverr_d = 1'b0;
      go_ready  = 1'b0;
      mem_we    = 1'b0;
      oor       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Only a genuine setup phase starts a transfer; an access
            // strobe without setup is ignored.
            if (bus.PSEL && !bus.PENABLE) begin
               addr_d  = bus.PADDR;
               write_d = bus.PWRITE;
               wdata_d = bus.PWDATA;
               cnt_d   = WAIT_L;
               if (WAIT_L == 4'd0) go_ready = 1'b1;
               else                state_d  = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bus.PSEL && bus.PENABLE) begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) go_ready = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_READY: begin
            // Completion or abort: either way the next cycle is IDLE.
            if (bus.PSEL && bus.PENABLE)
               mem_we = write_q && ({1'b0, addr_q} < DEPTH_W);
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Response is computed from the address being latched this edge,
      // which for zero wait states is still on the bus.
      if (go_ready) begin
         state_d   = ST_READY;
         pready_d  = 1'b1;
         oor       = ({1'b0, addr_d} >= DEPTH_W);
         pslverr_d = oor;
         if (!write_d)
            prdata_d = oor ? '0 : mem_q[addr_d[IW-1:0]];
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         write_q   <= 1'b0;
         wdata_q   <= '0;
         prdata_q  <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         write_q   <= write_d;
         wdata_q   <= wdata_d;
         prdata_q  <= prdata_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (mem_we) begin
         mem_q[addr_q[IW-1:0]] <= wdata_q;
      end
   end

   assign bus.PRDATA  = prdata_q;
   assign bus.PREADY  = pready_q;
   assign bus.PSLVERR = pslverr_q;
endmodule

// File: tb/tb_apb_slave.sv
module tb_apb_slave;
   localparam int WA = 2;   // wait states of instance A (PSEL1)
   localparam int WB = 0;   // wait states of instance B (PSEL2)

   typedef struct {
      logic       rd;
      logic [7:0] data;
      logic       err;
   } exp_t;

   logic       PCLK = 1'b0;
   logic       PRESETn = 1'b0;
   logic [1:0] psel = 2'b00;
   logic       penable = 1'b0;
   logic       pwrite = 1'b0;
   logic [7:0] paddr = 8'h00;
   logic [7:0] pwdata = 8'h00;

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   exp_t sb[$];
   logic [7:0] mdl [2][256];

   apb_slave_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) ifa ();
   apb_slave_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) ifb ();

   assign ifa.PSEL = psel[0];  assign ifb.PSEL = psel[1];
   assign ifa.PENABLE = penable; assign ifb.PENABLE = penable;
   assign ifa.PWRITE = pwrite;   assign ifb.PWRITE = pwrite;
   assign ifa.PADDR = paddr;     assign ifb.PADDR = paddr;
   assign ifa.PWDATA = pwdata;   assign ifb.PWDATA = pwdata;

   apb_slave #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(128), .WAIT_CYCLES(WA)) dut_a (
      .PCLK(PCLK), .PRESETn(PRESETn), .bus(ifa.slave));
   apb_slave #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(128), .WAIT_CYCLES(WB)) dut_b (
      .PCLK(PCLK), .PRESETn(PRESETn), .bus(ifb.slave));

   always #5 PCLK = ~PCLK;
   always @(posedge PCLK) cyc <= cyc + 1;

   task automatic clear_model();
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 256; i++) mdl[d][i] = 8'h00;
   endtask

   task automatic idle();
      psel = 2'b00; penable = 1'b0;
      @(posedge PCLK); #1;
   endtask

   // One transfer, started #1 after a rising edge; returns #1 after the
   // completion edge with the bus still selected (back-to-back capable).
   task automatic xfer(input int d, input logic wr, input logic [7:0] a,
                       input logic [7:0] wd, input bit chg);
      exp_t e;
      int k, c0, w;
      logic rdy, err, done;
      logic [7:0] rd;
      w = (d == 0) ? WA : WB;
      e.rd = !wr; e.err = (a >= 8'h80); e.data = e.err ? 8'h00 : mdl[d][a];
      sb.push_back(e);
      c0 = cyc;
      psel = 2'b00; psel[d] = 1'b1; penable = 1'b0;
      pwrite = wr; paddr = a; pwdata = wd;
      @(posedge PCLK); #1;
      penable = 1'b1;
      if (chg) begin paddr = a + 8'h01; pwdata = ~wd; end
      k = 0; done = 1'b0; rdy = 1'b0;
      while (!done) begin
         @(negedge PCLK);
         rdy = (d == 0) ? ifa.PREADY  : ifb.PREADY;
         err = (d == 0) ? ifa.PSLVERR : ifb.PSLVERR;
         rd  = (d == 0) ? ifa.PRDATA  : ifb.PRDATA;
         checks++;
         if (err && !rdy) begin
            errors++; $display("FAIL pslverr_qual a=%h got pslverr=1 pready=0 want pslverr=0", a);
         end
         if (rdy) done = 1'b1;
         else begin
            k++;
            if (k > 20) begin
               errors++; $display("FAIL timeout a=%h no PREADY after 20 cycles", a);
               done = 1'b1;
            end
         end
      end
      e = sb.pop_front();
      if (rdy) begin
         checks++;
         if (k !== w) begin errors++; $display("FAIL latency a=%h got %0d want %0d", a, k, w); end
         checks++;
         if (err !== e.err) begin errors++; $display("FAIL pslverr a=%h got %b want %b", a, err, e.err); end
         if (e.rd) begin
            checks++;
            if (rd !== e.data) begin errors++; $display("FAIL rdata a=%h got %h want %h", a, rd, e.data); end
         end
         @(posedge PCLK); #1;
         checks++;
         if (cyc - c0 !== w + 2) begin
            errors++; $display("FAIL xfer_cycles a=%h got %0d want %0d", a, cyc - c0, w + 2);
         end
         if (wr && a < 8'h80) mdl[d][a] = wd;
      end else begin
         psel = 2'b00; penable = 1'b0;
         @(posedge PCLK); #1;
      end
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({ifa.PREADY, ifa.PSLVERR, ifa.PRDATA, ifb.PREADY, ifb.PSLVERR, ifb.PRDATA} !== 20'h0) begin
         errors++; $display("FAIL reset_outputs got a=%b%b%h b=%b%b%h want all 0",
            ifa.PREADY, ifa.PSLVERR, ifa.PRDATA, ifb.PREADY, ifb.PSLVERR, ifb.PRDATA);
      end
      @(negedge PCLK); PRESETn = 1'b1;
      @(posedge PCLK); #1;
      checks++;
      if (ifa.PREADY !== 1'b0) begin errors++; $display("FAIL idle_pready got %b want 0", ifa.PREADY); end
   endtask

   task automatic test_write_read();
      xfer(0, 1'b1, 8'h10, 8'hA5, 1'b0);
      xfer(0, 1'b0, 8'h10, 8'h00, 1'b0);
      idle();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) xfer(1, 1'b1, i[7:0], 8'hC0 + i[7:0], 1'b0);
      for (int i = 0; i < 4; i++) xfer(1, 1'b0, i[7:0], 8'h00, 1'b0);
      idle();
   endtask

   task automatic test_out_of_range();
      xfer(0, 1'b1, 8'h00, 8'h99, 1'b0);
      xfer(0, 1'b1, 8'h80, 8'h55, 1'b0);
      xfer(0, 1'b0, 8'h80, 8'h00, 1'b0);
      xfer(0, 1'b0, 8'h00, 8'h00, 1'b0);
      xfer(0, 1'b1, 8'hFF, 8'h77, 1'b0);
      xfer(0, 1'b0, 8'h7F, 8'h00, 1'b0);
      idle();
   endtask

   task automatic test_abort();
      xfer(0, 1'b1, 8'h20, 8'h0A, 1'b0);
      idle();
      psel = 2'b01; penable = 1'b0; pwrite = 1'b1; paddr = 8'h20; pwdata = 8'h3C;
      @(posedge PCLK); #1;
      penable = 1'b1;
      @(posedge PCLK); #1;
      psel = 2'b00;
      for (int i = 0; i < 3; i++) begin
         @(negedge PCLK);
         checks++;
         if (ifa.PREADY !== 1'b0) begin errors++; $display("FAIL abort_pready cycle %0d got %b want 0", i, ifa.PREADY); end
      end
      penable = 1'b0;
      @(posedge PCLK); #1;
      xfer(0, 1'b0, 8'h20, 8'h00, 1'b0);
      idle();
   endtask

   task automatic test_stability();
      xfer(0, 1'b1, 8'h05, 8'h11, 1'b1);
      xfer(0, 1'b0, 8'h05, 8'h00, 1'b0);
      xfer(0, 1'b0, 8'h06, 8'h00, 1'b0);
      idle();
   endtask

   task automatic test_async_reset();
      xfer(0, 1'b0, 8'h10, 8'h00, 1'b0);   // PRDATA now 0xA5
      idle();
      psel = 2'b01; penable = 1'b0; pwrite = 1'b1; paddr = 8'h30; pwdata = 8'h77;
      @(posedge PCLK); #1;
      penable = 1'b1;
      @(negedge PCLK); #2;
      PRESETn = 1'b0;
      #1;
      checks++;
      if ({ifa.PREADY, ifa.PSLVERR, ifa.PRDATA} !== 10'h0) begin
         errors++; $display("FAIL async_reset got pready=%b pslverr=%b prdata=%h want 0 0 00",
            ifa.PREADY, ifa.PSLVERR, ifa.PRDATA);
      end
      psel = 2'b00; penable = 1'b0;
      clear_model();
      @(posedge PCLK); #2;
      PRESETn = 1'b1;
      @(posedge PCLK); #1;
      xfer(0, 1'b0, 8'h30, 8'h00, 1'b0);
      xfer(0, 1'b0, 8'h10, 8'h00, 1'b0);
      idle();
      xfer(1, 1'b0, 8'h02, 8'h00, 1'b0);
      idle();
   endtask

   initial begin
      clear_model();
      test_reset();
      test_write_read();
      test_back_to_back();
      test_out_of_range();
      test_abort();
      test_stability();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/apb_slave.md
# apb_slave

Byte-wide APB completer that answers the transfers issued by the team's APB master bridge on one of its select lines (PSEL1 or PSEL2). It holds a parameterised register file, inserts a programmable number of wait states through PREADY, and reports out-of-range accesses through PSLVERR. Two instances sit behind the bridge, one per 256-byte half of the 9-bit address map; PADDR[8] is decoded by the bridge and never reaches this block.

## Interface
- DATA_WIDTH, 8: PWDATA/PRDATA width.
- ADDR_WIDTH, 8: PADDR width seen by this block.
- DEPTH, 128: implemented locations; addresses DEPTH..2^ADDR_WIDTH-1 are out of range.
- WAIT_CYCLES, 2: wait states per transfer, 0..15.
- PCLK  in  1  clock; all state changes on the rising edge.
- PRESETn  in  1  reset, asynchronous, active-low.
- PSEL  in  1  select from bridge (PSEL1 or PSEL2).
- PENABLE  in  1  access-phase strobe.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PRDATA  out  DATA_WIDTH  read data, registered.
- PREADY  out  1  transfer completes when high in access phase, registered.
- PSLVERR  out  1  error response, qualified by PREADY, registered.

## Operation
- States: IDLE, WAIT, READY. Reset state IDLE.
- Reset: state IDLE, wait counter 0, every memory location 0x00, PRDATA 0x00, PREADY 0, PSLVERR 0. Reset is asynchronous: asserting PRESETn mid-transfer zeroes outputs immediately and discards any pending write.
- IDLE: PREADY=0, PSLVERR=0. On an edge with PSEL=1 and PENABLE=0 (setup phase), latch PADDR, PWRITE, PWDATA; load counter with WAIT_CYCLES; go to WAIT if WAIT_CYCLES>0, else READY. PSEL=1 with PENABLE=1 in IDLE (access without setup) is ignored, and the block stays in IDLE.
- WAIT: PREADY=0. Counter decrements each edge while PSEL=1 and PENABLE=1; when it reaches 0, go to READY.
- Entering READY: PREADY=1. PSLVERR=1 if latched address >= DEPTH. For a read, PRDATA loads mem[addr], or 0x00 when out of range. For a write, PRDATA holds its previous value.
- READY, at the edge with PSEL=1 and PENABLE=1: the transfer completes. A write commits latched PWDATA to mem[addr] only if in range. Go to IDLE; PREADY and PSLVERR return to 0.
- Abort: if PSEL=0 or PENABLE=0 at any edge in WAIT or READY, go to IDLE with no write, PREADY=0, PSLVERR=0.
- The block uses only latched address, direction and data. Input changes during the access phase have no effect.
- PRDATA holds its last read value outside READY.

## Timing
- Cycle T0 is the setup phase; the master raises PENABLE in T1. PREADY is high in cycle T1+WAIT_CYCLES. The transfer takes WAIT_CYCLES+2 cycles including setup.
- Write data becomes visible to a read whose setup edge follows the completion edge.
- Back-to-back transfers: the cycle after completion is IDLE, which serves as the next setup cycle with no dead cycle. Throughput is one transfer per WAIT_CYCLES+2 cycles.
- PSLVERR is never high unless PREADY is high.

## Test plan
- Reset: drive PRESETn=0 mid-WAIT -> PREADY, PSLVERR and PRDATA go to 0 without a clock edge; a subsequent read of the pending write address returns 0x00.
- Write then read, WAIT_CYCLES=2: write 0xA5 to 0x10, then read 0x10 -> PREADY high exactly 3 cycles after setup, PRDATA=0xA5, PSLVERR=0.
- Zero wait states, WAIT_CYCLES=0: back-to-back writes to 0x00..0x03, then reads -> PREADY high in every access cycle, each transfer takes 2 cycles, data matches.
- Out of range, DEPTH=128: write 0x55 to 0x80 -> PSLVERR=1 with PREADY; a read of 0x80 returns 0x00 with PSLVERR=1; mem[0x00] is unchanged.
- Abort: drop PSEL during WAIT of a write of 0x3C to 0x20 -> block returns to IDLE, PREADY stays 0, a read of 0x20 returns its old value.
- Input stability: change PADDR and PWDATA during WAIT of a write of 0x11 to 0x05 -> mem[0x05]=0x11, and the new address is not written.
